row_clear_engine: RTL

ROW_CLEAR_ENGINE -- requirements
Module: row_clear_engine

---
 rtl/row_clear_pkg.sv | 13 +
 rtl/row_clear_engine_full_row_detect.sv | 24 ++
 rtl/row_clear_engine.sv | 96 +++++++++
 3 files changed

// File: rtl/row_clear_pkg.sv
// Shared constants and state encoding for the row-clear engine.
package row_clear_pkg;

    localparam int DEF_ROWS  = 3;
    localparam int DEF_COLS  = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/row_clear_engine_full_row_detect.sv
// Flags the lowest-index row whose cells are all set, as a one-hot vector.
module full_row_detect
    import row_clear_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic [ROWS*COLS-1:0] grid_i,
    output logic [ROWS-1:0]      full_o
);

    logic [ROWS-1:0] row_full;

    always_comb begin
        row_full = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_full[r] = &grid_i[r*COLS +: COLS];
        end
    end

    // x & -x isolates the lowest set bit, which is the lowest-index full row.
    assign full_o = row_full & (~row_full + ROWS'(1));

endmodule

// File: rtl/row_clear_engine.sv
// Merges loaded cells into a grid, then collapses full rows one per cycle,
// counting cleared rows and pulsing done when no full row remains.
module row_clear_engine
    import row_clear_pkg::*;
#(
    parameter int COLS  = DEF_COLS,
    parameter int ROWS  = DEF_ROWS,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] ain,
    output logic [ROWS*COLS-1:0] grid,
    output logic [ROWS-1:0]      full,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     lines
);

    localparam int N = ROWS * COLS;

    state_t           state_q;
    logic [N-1:0]     grid_q;
    logic [N-1:0]     grid_d;
    logic             done_q;
    logic [CNT_W-1:0] lines_q;
    logic [CNT_W-1:0] lines_d;
    logic [ROWS-1:0]  at_or_above_full;
    logic [N-1:0]     shifted;

    full_row_detect #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_detect (
        .grid_i (grid_q),
        .full_o (full)
    );

    // Rows 0..r (r = flagged row) take the row above them; rows below r keep their value.
    always_comb begin
        logic acc;
        acc              = 1'b0;
        at_or_above_full = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            acc                 = acc | full[r];
            at_or_above_full[r] = acc;
        end
        shifted = grid_q << COLS;
        grid_d  = grid_q;
        for (int r = 0; r < ROWS; r++) begin
            if (at_or_above_full[r]) begin
                grid_d[r*COLS +: COLS] = shifted[r*COLS +: COLS];
            end
        end
    end

    always_comb begin
        lines_d = (lines_q == {CNT_W{1'b1}}) ? lines_q : lines_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grid_q  <= '0;
            lines_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        grid_q  <= grid_q | ain;
                        state_q <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (|full) begin
                        grid_q  <= grid_d;
                        lines_q <= lines_d;
                    end else begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grid  = grid_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign lines = lines_q;

endmodule
